// File: rtl/signal_conditioner.sv
// Multi-channel input conditioner: synchronise, optionally invert, debounce, register.
// Rise/fall/changed pulse flops exist only when SIGNAL_CONDITIONER_EDGE_EN is defined.
module signal_conditioner_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_x,
  output logic o_level
`ifdef SIGNAL_CONDITIONER_EDGE_EN
  ,
  output logic o_rise_nxt,
  output logic o_fall_nxt
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [CW-1:0]          r_cnt;
  logic                   w_sync;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_level = r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= {SYNC_STAGES{RESET_LEVEL}};
      r_level <= RESET_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_x};
      // Debounce only advances on enabled cycles; a return to the stable level clears the count.
      if (i_enable) begin
        if (w_sync == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_level <= w_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

`ifdef SIGNAL_CONDITIONER_EDGE_EN
  logic w_accept;
  assign w_accept   = i_enable && (w_sync != r_level) && (r_cnt == CNT_MAX);
  assign o_rise_nxt = w_accept & w_sync;
  assign o_fall_nxt = w_accept & ~w_sync;
`endif
endmodule

module signal_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] invertMask,
  input  logic [CHANNELS-1:0] inSignal,
  output logic [CHANNELS-1:0] outSignal,
  output logic [CHANNELS-1:0] risePulse,
  output logic [CHANNELS-1:0] fallPulse,
  output logic                changed
);
  logic [CHANNELS-1:0] w_x;
  logic [CHANNELS-1:0] w_level;
`ifdef SIGNAL_CONDITIONER_EDGE_EN
  logic [CHANNELS-1:0] w_rise_nxt;
  logic [CHANNELS-1:0] w_fall_nxt;
`endif

  // Inversion ahead of the synchroniser, so a mask change debounces like an input edge.
  assign w_x       = inSignal ^ invertMask;
  assign outSignal = w_level;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    signal_conditioner_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_enable  (enable),
      .i_x       (w_x[g]),
      .o_level   (w_level[g])
`ifdef SIGNAL_CONDITIONER_EDGE_EN
      ,
      .o_rise_nxt(w_rise_nxt[g]),
      .o_fall_nxt(w_fall_nxt[g])
`endif
    );
  end

`ifdef SIGNAL_CONDITIONER_EDGE_EN
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic                r_changed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign risePulse = r_rise;
  assign fallPulse = r_fall;
  assign changed   = r_changed;
`else
  assign risePulse = '0;
  assign fallPulse = '0;
  assign changed   = 1'b0;
`endif
endmodule

// File: tb/tb_signal_conditioner.sv
// Directed bench for signal_conditioner (default parameters); pulse expectations follow
// SIGNAL_CONDITIONER_EDGE_EN so the same run covers both builds.
module tb_signal_conditioner;
`ifdef SIGNAL_CONDITIONER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] invertMask;
  logic [3:0] inSignal;
  logic [3:0] outSignal;
  logic [3:0] risePulse;
  logic [3:0] fallPulse;
  logic       changed;

  int n_assert = 0;
  int n_fail   = 0;

  signal_conditioner #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_LEVEL(1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .invertMask(invertMask),
    .inSignal  (inSignal),
    .outSignal (outSignal),
    .risePulse (risePulse),
    .fallPulse (fallPulse),
    .changed   (changed)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_out, input logic [3:0] e_rise,
                         input logic [3:0] e_fall, input logic e_chg);
    logic [3:0] x_rise;
    logic [3:0] x_fall;
    logic       x_chg;
    x_rise = EDGE ? e_rise : 4'b0000;
    x_fall = EDGE ? e_fall : 4'b0000;
    x_chg  = EDGE ? e_chg  : 1'b0;
    n_assert++;
    assert (outSignal === e_out) else begin
      n_fail++;
      $error("FAIL %s outSignal: observed %b expected %b", tag, outSignal, e_out);
    end
    n_assert++;
    assert (risePulse === x_rise) else begin
      n_fail++;
      $error("FAIL %s risePulse: observed %b expected %b", tag, risePulse, x_rise);
    end
    n_assert++;
    assert (fallPulse === x_fall) else begin
      n_fail++;
      $error("FAIL %s fallPulse: observed %b expected %b", tag, fallPulse, x_fall);
    end
    n_assert++;
    assert (changed === x_chg) else begin
      n_fail++;
      $error("FAIL %s changed: observed %b expected %b", tag, changed, x_chg);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    invertMask = 4'b0000;
    inSignal   = 4'b0000;

    // Reset state, during and after reset
    #2;
    chk_all("reset_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("reset_held", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("post_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    // Step on channel 0: accepted at edge 18, one-cycle rise pulse
    inSignal = 4'b0001;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("step0_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("step0_edge18", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    tick();
    chk_all("step0_edge19", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Glitch on channel 1 for 10 cycles is rejected
    inSignal = 4'b0011;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("glitch_high", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end
    inSignal = 4'b0001;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk_all("glitch_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end

    // Step on channel 2 with 8 disabled cycles after 5 counted: accepted at edge 26
    inSignal = 4'b0101;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_all("en_count", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end
    enable = 1'b0;
    for (int k = 8; k <= 15; k++) begin
      tick();
      chk_all("en_hold", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end
    enable = 1'b1;
    for (int k = 16; k <= 25; k++) begin
      tick();
      chk_all("en_resume", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("en_edge26", 4'b0101, 4'b0100, 4'b0000, 1'b1);
    tick();
    chk_all("en_edge27", 4'b0101, 4'b0000, 4'b0000, 1'b0);

    // Inversion mask on channel 3 rises, then driving the input high falls it again
    invertMask = 4'b1000;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("inv_rise_wait", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("inv_rise_edge18", 4'b1101, 4'b1000, 4'b0000, 1'b1);
    tick();
    chk_all("inv_rise_edge19", 4'b1101, 4'b0000, 4'b0000, 1'b0);
    inSignal = 4'b1101;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("inv_fall_wait", 4'b1101, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("inv_fall_edge18", 4'b0101, 4'b0000, 4'b1000, 1'b1);
    tick();
    chk_all("inv_fall_edge19", 4'b0101, 4'b0000, 4'b0000, 1'b0);

    // Asynchronous reset mid-count (channel 1 count at 10 after edge 12)
    inSignal = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all("midcnt_wait", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    end
    #2 reset = 1'b1;
    #1;
    chk_all("midcnt_async_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    chk_all("midcnt_rst_held", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;
    // x is now 4'b0111: full latency applies from the release point
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("rel_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("rel_edge18", 4'b0111, 4'b0111, 4'b0000, 1'b1);

    // Asynchronous reset while the pulse is high
    #2 reset = 1'b1;
    #1;
    chk_all("midpulse_async_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("midpulse_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
